// File: rtl/ram_requester.sv
// ram_requester: NoC initiator that runs one write/read-back pass against the
// single-port RAM node RAM_NODE. On start it writes NUM_WORDS words
// (addr = BASE_ADDR+i wrapped, data = addr ^ SEED), waits for every write ack,
// reads the same words back and compares the data. Credit-based flow control
// keeps at most CREDITS requests in flight.
//
// Ports:
//   clk, rst (active-low async), start (one-cycle pulse, honoured in IDLE/DONE)
//   o_packed_out/o_dest_out/o_valid_out/o_ready_in : request channel,
//     flit = {data, addr, write_en, read_en, src}
//   i_packed_in/i_valid_in/i_ready_out : response channel, flit = {data, node}
//   done, error, err_count : pass status (err_count saturates at 255)
//   dbg_state, dbg_credits : FSM state and credit counter for observation
//
// Handshake: a flit moves on a cycle where valid & ready are both high. The
// request side holds o_valid_out/o_packed_out stable until that cycle and may
// present the next flit on the following cycle. The response side is always
// ready (i_ready_out = 1).
module ram_requester #(
  parameter int WIDTH        = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NODE         = 0,
  parameter int RAM_NODE     = 15,
  parameter int CREDITS      = 4,
  parameter int NUM_WORDS    = 8,
  parameter int BASE_ADDR    = 0,
  parameter int SEED         = 'h5A,
  parameter int PACKED_OUT   = WIDTH + ADDR_WIDTH + N_ADDR_WIDTH + 2,
  parameter int PACKED_IN    = WIDTH + N_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [PACKED_OUT-1:0]   o_packed_out,
  output logic [N_ADDR_WIDTH-1:0] o_dest_out,
  output logic                    o_valid_out,
  input  logic                    o_ready_in,
  input  logic [PACKED_IN-1:0]    i_packed_in,
  input  logic                    i_valid_in,
  output logic                    i_ready_out,
  output logic                    done,
  output logic                    error,
  output logic [7:0]              err_count,
  output logic [2:0]              dbg_state,
  output logic [3:0]              dbg_credits
);

  localparam int IW = $clog2(NUM_WORDS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_WAIT_W = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_WAIT_R = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [IW-1:0]           NUM_IW   = IW'(NUM_WORDS);
  localparam logic [IW-1:0]           ONE_IW   = IW'(1);
  localparam logic [3:0]              CRED_MAX = 4'(CREDITS);
  localparam logic [N_ADDR_WIDTH-1:0] RAM_ID   = N_ADDR_WIDTH'(RAM_NODE);
  localparam logic [N_ADDR_WIDTH-1:0] NODE_ID  = N_ADDR_WIDTH'(NODE);
  localparam logic [WIDTH-1:0]        SEED_W   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0]        ACK      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0]   BASE_A   = ADDR_WIDTH'(BASE_ADDR);

  logic [2:0]              state;
  logic [IW-1:0]           idx;      // next word to issue
  logic [IW-1:0]           rd_idx;   // next read response expected
  logic [3:0]              credits;
  logic [3:0]              credits_nxt;
  logic                    xfer;
  logic                    rsp;
  logic                    can_issue;
  logic                    mismatch;
  logic [WIDTH-1:0]        rsp_data;
  logic [N_ADDR_WIDTH-1:0] rsp_node;

  function automatic logic [WIDTH-1:0] exp_data(input logic [ADDR_WIDTH-1:0] a);
    return WIDTH'(a) ^ SEED_W;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IW-1:0] i);
    return BASE_A + ADDR_WIDTH'(i);
  endfunction

  function automatic logic [PACKED_OUT-1:0] pack_req(input logic wr,
                                                     input logic [ADDR_WIDTH-1:0] a);
    return {wr ? exp_data(a) : {WIDTH{1'b0}}, a, wr, ~wr, NODE_ID};
  endfunction

  assign o_dest_out  = RAM_ID;
  assign i_ready_out = 1'b1;
  assign dbg_state   = state;
  assign dbg_credits = credits;

  assign xfer     = o_valid_out & o_ready_in;
  assign rsp      = i_valid_in & i_ready_out;
  assign rsp_data = i_packed_in[PACKED_IN-1:N_ADDR_WIDTH];
  assign rsp_node = i_packed_in[N_ADDR_WIDTH-1:0];

  // A response with the counter already full would overflow it; it is left
  // unchanged and the response is flagged as a mismatch below.
  always_comb begin
    credits_nxt = credits;
    if (xfer && !rsp)
      credits_nxt = credits - 4'd1;
    else if (!xfer && rsp && credits != CRED_MAX)
      credits_nxt = credits + 4'd1;
  end

  // A new flit is loaded only when the output slot frees up this cycle and a
  // credit will still be available for it, so a presented-but-stalled request
  // always already owns a credit.
  assign can_issue = (credits_nxt != 4'd0) && (!o_valid_out || xfer);

  always_comb begin
    mismatch = 1'b0;
    if (rsp) begin
      if (rsp_node != RAM_ID || credits == CRED_MAX)
        mismatch = 1'b1;
      case (state)
        S_WRITE, S_WAIT_W: if (rsp_data != ACK) mismatch = 1'b1;
        S_READ, S_WAIT_R:  if (rsp_data != exp_data(word_addr(rd_idx))) mismatch = 1'b1;
        default:           mismatch = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      rd_idx       <= '0;
      credits      <= CRED_MAX;
      o_valid_out  <= 1'b0;
      o_packed_out <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      credits <= credits_nxt;
      if (rsp && (state == S_READ || state == S_WAIT_R))
        rd_idx <= rd_idx + ONE_IW;
      if (mismatch) begin
        error <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // A response landing in the start cycle still counts against the new pass.
            err_count <= {7'd0, mismatch};
            error     <= mismatch;
            done      <= 1'b0;
            rd_idx    <= '0;
            state     <= S_WRITE;
            if (can_issue) begin
              o_valid_out  <= 1'b1;
              o_packed_out <= pack_req(1'b1, word_addr({IW{1'b0}}));
              idx          <= ONE_IW;
            end else begin
              idx <= '0;
            end
          end
        end
        S_WRITE, S_READ: begin
          if (idx != NUM_IW && can_issue) begin
            o_valid_out  <= 1'b1;
            o_packed_out <= pack_req(state == S_WRITE, word_addr(idx));
            idx          <= idx + ONE_IW;
          end else if (xfer) begin
            o_valid_out <= 1'b0;
            if (idx == NUM_IW)
              state <= (state == S_WRITE) ? S_WAIT_W : S_WAIT_R;
          end
        end
        S_WAIT_W: begin
          if (credits == CRED_MAX) begin
            state  <= S_READ;
            idx    <= '0;
            rd_idx <= '0;
          end
        end
        S_WAIT_R: begin
          if (credits == CRED_MAX) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_requester.md
Name: ram_requester

Overview:
- NoC initiator paired with the single-port RAM responder on the onchip_ram_credits design.
- On `start` it writes NUM_WORDS words to the RAM node, waits for every write ack, reads the same words back and checks the returned data.
- Flow control is credit-based: at most CREDITS requests are in flight.
- Reports `done`, `error` and a mismatch count. It sits on a NoC fabric port at node NODE.

Parameters:
- WIDTH, 8, data word width.
- ADDR_WIDTH, 4, RAM address width.
- N, 16, number of NoC nodes.
- N_ADDR_WIDTH, $clog2(N), node-id width.
- NODE, 0, this block's node id, sent as the request source.
- RAM_NODE, 15, destination node id of the RAM.
- CREDITS, 4, maximum number of outstanding requests (1..15).
- NUM_WORDS, 8, words per pass (1..2**ADDR_WIDTH).
- BASE_ADDR, 0, first RAM address.
- SEED, 8'h5A, data pattern seed.
- PACKED_OUT, WIDTH+ADDR_WIDTH+N_ADDR_WIDTH+2, request flit width.
- PACKED_IN, WIDTH+N_ADDR_WIDTH, response flit width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, active-low asynchronous
- start  in  1  one-cycle pulse; begins a pass from IDLE or DONE
- o_packed_out  out  PACKED_OUT  request {data, addr, write_en, read_en, src}, MSB first
- o_dest_out  out  N_ADDR_WIDTH  request destination, always RAM_NODE
- o_valid_out  out  1  request valid
- o_ready_in  in  1  fabric accepts request
- i_packed_in  in  PACKED_IN  response {data, node}
- i_valid_in  in  1  response valid
- i_ready_out  out  1  response accepted
- done  out  1  pass complete
- error  out  1  any mismatch seen in the pass
- err_count  out  8  number of mismatches, saturating at 255

Behaviour:
- Single clock `clk`; reset `rst` is asynchronous and active-low.
- Reset values:
  - o_packed_out, o_valid_out, done, error and err_count are 0.
  - o_dest_out is RAM_NODE; i_ready_out is 1.
  - Credit counter is CREDITS; state is IDLE.
- Address and data rules:
  - Word i (0..NUM_WORDS-1) uses addr = (BASE_ADDR+i) mod 2**ADDR_WIDTH, truncated.
  - Expected data = (addr zero-extended to WIDTH) XOR SEED[WIDTH-1:0].
  - The write-ack pattern is MSB=1 with all other bits 0 (8'h80 at WIDTH=8).
- Request handshake:
  - A request transfers when o_valid_out & o_ready_in.
  - o_valid_out and o_packed_out are registered and stay stable until the transfer.
  - A new request may be presented the cycle after a transfer (full throughput).
  - Requests are issued only while credits > 0.
- Credits:
  - Decrement by 1 on a request transfer; increment by 1 on a response transfer (i_valid_in & i_ready_out).
  - Both in the same cycle: the counter is unchanged.
  - A response arriving with credits == CREDITS is an error: err_count increments and the counter does not overflow.
- i_ready_out is held at 1 in all states, so responses are never backpressured.
- State machine:
  - IDLE: no requests. On start, clear err_count, error and done, then go to WRITE.
  - WRITE: issue write requests (write_en=1, read_en=0, data=expected) for i = 0..NUM_WORDS-1. After the last write transfers, go to WAIT_W.
  - WAIT_W: wait until credits == CREDITS, then go to READ.
  - READ: issue read requests (write_en=0, read_en=1, data=0) for i = 0..NUM_WORDS-1. After the last read transfers, go to WAIT_R.
  - WAIT_R: wait until credits == CREDITS, then go to DONE.
  - DONE: done=1 and hold. On start, behave as in IDLE (restart the pass).
- Response checking, applied on every accepted response:
  - node != RAM_NODE is a mismatch.
  - In WRITE or WAIT_W: data != ack pattern is a mismatch.
  - In READ or WAIT_R: responses are in order, tracked by a read-response index. data != expected(index) is a mismatch; the index increments on each response.
  - A response in IDLE or DONE is a mismatch.
- Mismatch effects: err_count++ (saturating at 255) and error is set sticky until the next start.
- `start` is ignored outside IDLE and DONE.
- Reset asserted mid-pass aborts immediately to reset values. In-flight responses arriving after reset release are counted as IDLE mismatches.
- Latency: the first request is valid on the cycle after start is sampled.

Test Plan:
- Default params, ideal RAM model (1-cycle response), o_ready_in=1, start → 8 writes to addr 0..7 with data 5A,5B,58,59,5E,5F,5C,5D, then 8 reads. Expect done=1, error=0, err_count=0.
- RAM model delays responses 20 cycles → never more than 4 requests outstanding. The 5th request waits until the first ack arrives, then transfers the cycle after; pass still clean.
- o_ready_in toggled randomly → o_packed_out is stable while o_valid_out=1 and ~o_ready_in; all 16 requests transfer exactly once, in order.
- RAM model corrupts read of addr 3 (returns 00) and returns an ack with node=7 → err_count=2, error=1, done=1.
- Response transfers in the same cycle as a request transfer → credit count unchanged. Unsolicited response in IDLE → err_count=1, credits stay 4.
- rst low during READ, then start → clean second pass, err_count=0. BASE_ADDR=14, NUM_WORDS=4 → addresses wrap as 14,15,0,1.
